parallel_bus_master: RTL and testbench

Synchronous initiator for the 16-bit asynchronous SRAM-style bus (data[15:0], active-low WE/OE/CE) used between the ARM and the FPGA. It turns a valid/ready request into a complete write or read cycle with programmable setup, strobe, hold and turnaround phases. The pad tri-state buffer lives at the top level; this block only produces the data-out value and the output-enable signal for it. Its uses are driving the FPGA slave from a second board, a loopback bench, or an external SRAM.

---
 rtl/parallel_bus_pkg.sv | 33 +++
 rtl/parallel_bus_master_phase_timer.sv | 27 ++
 rtl/parallel_bus_master.sv | 149 ++++++++++++++
 tb/tb_parallel_bus_master.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parallel_bus_pkg.sv
// Shared types and default timing for the parallel bus master.
// State encoding, phase defaults and counter sizing helper.
package parallel_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    TURN
  } bus_state_t;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_SETUP_CYC  = 2;
  localparam int DEF_STROBE_CYC = 4;
  localparam int DEF_HOLD_CYC   = 2;
  localparam int DEF_TURN_CYC   = 2;

  function automatic int max4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/parallel_bus_master_phase_timer.sv
// Loadable down-counter that times each bus phase.
// done is high while the count sits at zero.
module phase_timer #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/parallel_bus_master.sv
// Initiator for the 16-bit asynchronous SRAM-style bus.
// Turns a valid/ready request into a timed write or read cycle.
module parallel_bus_master
  import parallel_bus_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int TURN_CYC   = DEF_TURN_CYC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [DATA_W-1:0] bus_data_out,
  output logic              bus_data_oe,
  input  logic [DATA_W-1:0] bus_data_in,
  output logic              bus_ce_n,
  output logic              bus_we_n,
  output logic              bus_oe_n
);

  localparam int CW =
    $clog2(max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, TURN_CYC)) + 1;

  if (SETUP_CYC < 1 || STROBE_CYC < 1 ||
      HOLD_CYC < 1 || TURN_CYC < 1) begin : g_param_check
    $error("parallel_bus_master: phase lengths must be >= 1");
  end

  bus_state_t    state;
  bus_state_t    state_nxt;
  logic          accept;
  logic          wr_q;
  logic          wr_nxt;
  logic          timer_load;
  logic [CW-1:0] timer_val;
  logic          timer_done;
  logic          ce_d;
  logic          we_d;
  logic          oe_d;
  logic          doe_d;
  logic          rsp_d;
  logic          cap;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);
  assign wr_nxt    = accept ? req_write : wr_q;

  phase_timer #(
    .W(CW)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .load (timer_load),
    .value(timer_val),
    .done (timer_done)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)     state_nxt = SETUP;
      SETUP:   if (timer_done) state_nxt = STROBE;
      STROBE:  if (timer_done) state_nxt = HOLD;
      HOLD:    if (timer_done) state_nxt = TURN;
      TURN:    if (timer_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The timer counts the phase being entered down to zero.
  always_comb begin
    timer_load = (state_nxt != state) && (state_nxt != IDLE);
    timer_val  = '0;
    unique case (state_nxt)
      SETUP:   timer_val = CW'(SETUP_CYC - 1);
      STROBE:  timer_val = CW'(STROBE_CYC - 1);
      HOLD:    timer_val = CW'(HOLD_CYC - 1);
      TURN:    timer_val = CW'(TURN_CYC - 1);
      default: timer_val = '0;
    endcase
  end

  // Bus pins are registered from the upcoming state, so they glitch-free
  // line up with the phase boundaries.
  always_comb begin
    ce_d  = 1'b1;
    we_d  = 1'b1;
    oe_d  = 1'b1;
    doe_d = 1'b0;
    unique case (state_nxt)
      SETUP: begin
        ce_d  = 1'b0;
        doe_d = wr_nxt;
      end
      STROBE: begin
        ce_d  = 1'b0;
        doe_d = wr_nxt;
        we_d  = !wr_nxt;
        oe_d  = wr_nxt;
      end
      HOLD: begin
        ce_d  = 1'b0;
        doe_d = wr_nxt;
      end
      default: ;
    endcase
    rsp_d = (state == STROBE) && (state_nxt == HOLD);
    cap   = rsp_d && !wr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q         <= 1'b0;
      bus_ce_n     <= 1'b1;
      bus_we_n     <= 1'b1;
      bus_oe_n     <= 1'b1;
      bus_data_oe  <= 1'b0;
      bus_data_out <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      bus_ce_n    <= ce_d;
      bus_we_n    <= we_d;
      bus_oe_n    <= oe_d;
      bus_data_oe <= doe_d;
      rsp_valid   <= rsp_d;
      if (accept) begin
        wr_q <= req_write;
        if (req_write) bus_data_out <= req_wdata;
      end
      if (cap) rsp_rdata <= bus_data_in;
    end
  end

endmodule

// File: tb/tb_parallel_bus_master.sv
// Self-checking bench for parallel_bus_master.
// Scoreboard of responses plus cycle-exact pin checks.
module tb_parallel_bus_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic [15:0] bus_data_out;
  logic        bus_data_oe;
  logic [15:0] bus_data_in;
  logic        bus_ce_n;
  logic        bus_we_n;
  logic        bus_oe_n;

  logic        req_valid1;
  logic        req_ready1;
  logic        req_write1;
  logic [15:0] req_wdata1;
  logic        rsp_valid1;
  logic [15:0] rsp_rdata1;
  logic        busy1;
  logic [15:0] bus_data_out1;
  logic        bus_data_oe1;
  logic [15:0] bus_data_in1;
  logic        bus_ce_n1;
  logic        bus_we_n1;
  logic        bus_oe_n1;

  logic [15:0] rd_model;
  logic [15:0] pad;
  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          prev_held = 1'b0;

  always #5 clock = ~clock;

  parallel_bus_master dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .busy        (busy),
    .bus_data_out(bus_data_out),
    .bus_data_oe (bus_data_oe),
    .bus_data_in (bus_data_in),
    .bus_ce_n    (bus_ce_n),
    .bus_we_n    (bus_we_n),
    .bus_oe_n    (bus_oe_n)
  );

  parallel_bus_master #(
    .SETUP_CYC (1),
    .STROBE_CYC(1),
    .HOLD_CYC  (1),
    .TURN_CYC  (1)
  ) dut1 (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid1),
    .req_ready   (req_ready1),
    .req_write   (req_write1),
    .req_wdata   (req_wdata1),
    .rsp_valid   (rsp_valid1),
    .rsp_rdata   (rsp_rdata1),
    .busy        (busy1),
    .bus_data_out(bus_data_out1),
    .bus_data_oe (bus_data_oe1),
    .bus_data_in (bus_data_in1),
    .bus_ce_n    (bus_ce_n1),
    .bus_we_n    (bus_we_n1),
    .bus_oe_n    (bus_oe_n1)
  );

  // Pad model: master drives on writes, the slave answers while OE is low.
  assign pad = bus_data_oe ? bus_data_out :
               (!bus_oe_n ? rd_model : 16'hFFFF);
  assign bus_data_in  = pad;
  assign bus_data_in1 = 16'h0000;

  // FPGA slave: 4-stage edge detector on WE, data delayed alongside.
  logic [3:0]  we_sh = 4'hF;
  logic [15:0] d_sh [4];
  logic [15:0] slave_reg = 16'h0;

  always @(posedge clock) begin
    we_sh   <= {we_sh[2:0], bus_we_n};
    d_sh[0] <= pad;
    d_sh[1] <= d_sh[0];
    d_sh[2] <= d_sh[1];
    d_sh[3] <= d_sh[2];
    if (!we_sh[3] && we_sh[2]) slave_reg <= d_sh[3];
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_rd = 16'h0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      sb.delete();
      exp_rd <= 16'h0;
    end else if (req_valid && req_ready) begin
      sb.push_back('{cyc + 7, req_write ? exp_rd : rd_model});
      if (!req_write) exp_rd <= rd_model;
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (cyc > 1) begin
      check("inv_we_oe", {31'b0, !bus_we_n && !bus_oe_n}, 0);
      check("inv_drv_oe", {31'b0, bus_data_oe && !bus_oe_n}, 0);
      check("inv_ce", {31'b0, (!bus_we_n || !bus_oe_n) && bus_ce_n}, 0);
      check("inv1_we_oe", {31'b0, !bus_we_n1 && !bus_oe_n1}, 0);
      check("inv1_ce", {31'b0, (!bus_we_n1 || !bus_oe_n1) && bus_ce_n1}, 0);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rsp_cycle", cyc, e.cyc);
          check("rsp_rdata", rsp_rdata, e.rdata);
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        check("rsp_missing", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  // Issues one request; returns at the negedge of cycle 11.
  task automatic run_txn(
    input logic        wr,
    input logic [15:0] wd,
    input logic [15:0] rd,
    input bit          hold
  );
    int   n;
    logic in_ce;
    logic strobe;
    rd_model  = rd;
    req_valid = 1'b1;
    req_write = wr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("accept_timeout", {31'b0, n >= 50}, 0);
    if (prev_held) check("b2b_accept_wait", n, 0);
    prev_held = hold;
    @(posedge clock);
    #1;
    if (!hold) req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      in_ce  = (k <= 8);
      strobe = (k >= 3 && k <= 6);
      check("ce_n", bus_ce_n, !in_ce);
      check("we_n", bus_we_n, !(wr && strobe));
      check("oe_n", bus_oe_n, !(!wr && strobe));
      check("data_oe", bus_data_oe, wr && in_ce);
      if (wr && in_ce) check("data_out", bus_data_out, wd);
      check("busy", busy, 1);
    end
    @(negedge clock);
    check("ready_c11", req_ready, 1);
    check("busy_c11", busy, 0);
  endtask

  int r1[$];
  int y1[$];
  int w1[$];

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_wdata  = 16'hFFFF;
    req_valid1 = 1'b0;
    req_write1 = 1'b0;
    req_wdata1 = 16'h0;
    rd_model   = 16'h0;
    repeat (3) @(negedge clock);
    check("rst_ce_n", bus_ce_n, 1);
    check("rst_we_n", bus_we_n, 1);
    check("rst_oe_n", bus_oe_n, 1);
    check("rst_data_oe", bus_data_oe, 0);
    check("rst_data_out", bus_data_out, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    req_valid = 1'b0;
    reset     = 1'b0;
    #1;
    check("ready_after_rst", req_ready, 1);

    run_txn(1'b1, 16'hA5C3, 16'h0000, 1'b0);
    check("slave_a5c3", slave_reg, 16'hA5C3);
    run_txn(1'b0, 16'h0000, 16'h1234, 1'b0);
    check("read_hold", rsp_rdata, 16'h1234);

    run_txn(1'b1, 16'h5A5A, 16'h0000, 1'b1);
    run_txn(1'b0, 16'h0000, 16'hCAFE, 1'b0);

    // Write aborted by reset in cycle 4.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_wdata = 16'h3C3C;
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clock);
    check("abort_c4_we", bus_we_n, 0);
    reset = 1'b1;
    @(negedge clock);
    check("abort_ce_n", bus_ce_n, 1);
    check("abort_we_n", bus_we_n, 1);
    check("abort_oe_n", bus_oe_n, 1);
    check("abort_data_oe", bus_data_oe, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", req_ready, 0);
    reset = 1'b0;
    #1;
    check("abort_ready_after", req_ready, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check("abort_no_rsp", rsp_valid, 0);
    end

    run_txn(1'b1, 16'hBEEF, 16'h0000, 1'b0);
    check("slave_beef", slave_reg, 16'hBEEF);

    // Minimum-length phases on the second instance.
    req_valid1 = 1'b1;
    req_write1 = 1'b1;
    req_wdata1 = 16'h0F0F;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (rsp_valid1) r1.push_back(k);
      if (req_ready1) y1.push_back(k);
      if (!bus_we_n1) w1.push_back(k);
    end
    req_valid1 = 1'b0;
    check("fast_rsp_n", r1.size(), 2);
    check("fast_rsp0", r1.size() > 0 ? r1[0] : -1, 3);
    check("fast_rsp1", r1.size() > 1 ? r1[1] : -1, 8);
    check("fast_rdy0", y1.size() > 0 ? y1[0] : -1, 5);
    check("fast_rdy1", y1.size() > 1 ? y1[1] : -1, 10);
    check("fast_we0", w1.size() > 0 ? w1[0] : -1, 2);
    check("fast_we_n", w1.size(), 2);

    repeat (3) @(negedge clock);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
